// File: rtl/kpyd_pkg.sv
// Shared types and helpers for the kpyd keypad scan controller.
// Holds the scan FSM state encoding and the key-code encoder.
package kpyd_pkg;

    typedef enum logic [1:0] {
        scan_s     = 2'd0,
        debounce_s = 2'd1,
        report_s   = 2'd2,
        release_s  = 2'd3
    } scan_state_e;

    // Upper bound on row lines the encoder searches.
    localparam int unsigned KPYD_MAX_ROWS = 32;

    // Key code for a captured row pattern: lowest set row index times the
    // column count, plus the active column. An empty pattern encodes row 0.
    function automatic int unsigned kpyd_key_encode(
        input logic [KPYD_MAX_ROWS-1:0] pat,
        input int unsigned              rows,
        input int unsigned              cols,
        input int unsigned              col
    );
        int unsigned row_idx;
        row_idx = 0;
        // Walk downwards so the last hit, the lowest set row, wins.
        for (int i = KPYD_MAX_ROWS - 1; i >= 0; i--) begin
            if ((i < int'(rows)) && pat[i]) begin
                row_idx = unsigned'(i);
            end
        end
        return row_idx * cols + col;
    endfunction

endpackage

// File: rtl/kpyd_delay_counter.sv
// Loadable down-counter shared by the settle, debounce and release phases.
// done_o is high while the count sits at zero; a load takes priority over
// counting, and the counter holds at zero until the next load.
module kpyd_delay_counter #(
    parameter int unsigned width_p     = 8,
    parameter int unsigned reset_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] value_i,
    output logic               done_o
);

    logic [width_p-1:0] cnt_q;
    logic [width_p-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, preset by reset so the first phase starts timed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= width_p'(reset_val_p);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/kpyd_scan_ctrl.sv
// Keypad scan controller: walks a one-hot column drive across the matrix,
// debounces a detected press and reports one key code per press on a
// valid/ready interface. All outputs come straight from registers.
// Optional build macro KPYD_SCAN_REPEAT_EN enables auto-repeat while a key
// stays held; without it each press produces exactly one report.
module kpyd_scan_ctrl
    import kpyd_pkg::*;
#(
    parameter int unsigned cols_p            = 4,
    parameter int unsigned rows_p            = 4,
    parameter int unsigned settle_cycles_p   = 16,
    parameter int unsigned debounce_cycles_p = 1000,
    parameter int unsigned repeat_cycles_p   = 500000,
    localparam int unsigned key_w_lp         = $clog2(rows_p * cols_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [rows_p-1:0]   row_i,
    output logic [cols_p-1:0]   col_o,
    output logic [key_w_lp-1:0] key_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int unsigned col_w_lp   = (cols_p > 1) ? $clog2(cols_p) : 1;
    localparam int unsigned max_sd_lp  = (settle_cycles_p > debounce_cycles_p) ?
                                         settle_cycles_p : debounce_cycles_p;
    localparam int unsigned max_cyc_lp = (max_sd_lp > repeat_cycles_p) ?
                                         max_sd_lp : repeat_cycles_p;
    localparam int unsigned cnt_w_lp   = $clog2(max_cyc_lp) + 1;

    // Settle loads the full count: the sample is taken on the cycle after
    // the count expires, giving settle+1 cycles of dwell per column.
    localparam logic [cnt_w_lp-1:0] settle_val_lp = cnt_w_lp'(settle_cycles_p);
    // Debounce/release phases count N consecutive samples, ending at zero.
    localparam logic [cnt_w_lp-1:0] deb_val_lp    = cnt_w_lp'(debounce_cycles_p - 1);
    localparam logic [col_w_lp-1:0] col_last_lp   = col_w_lp'(cols_p - 1);

    scan_state_e           state_q, state_d;
    logic [col_w_lp-1:0]   col_q, col_d;
    logic [rows_p-1:0]     pat_q, pat_d;
    logic [key_w_lp-1:0]   key_q, key_d;
    logic                  valid_q, valid_d;
    logic [cols_p-1:0]     col_oh_q, col_oh_d;

    logic [col_w_lp-1:0]   col_inc;
    logic                  cnt_load;
    logic [cnt_w_lp-1:0]   cnt_val;
    logic                  cnt_done;

    assign col_inc = (col_q == col_last_lp) ? '0 : col_q + 1'b1;

    kpyd_delay_counter #(
        .width_p     (cnt_w_lp),
        .reset_val_p (settle_cycles_p)
    ) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (cnt_load),
        .value_i (cnt_val),
        .done_o  (cnt_done)
    );

`ifdef KPYD_SCAN_REPEAT_EN
    // The reload happens in the report cycle, so two cycles of the repeat
    // period are already spent when the countdown starts.
    localparam logic [cnt_w_lp-1:0] rpt_val_lp =
        cnt_w_lp'((repeat_cycles_p > 2) ? repeat_cycles_p - 2 : 0);

    logic rpt_load;
    logic rpt_done;

    kpyd_delay_counter #(
        .width_p     (cnt_w_lp),
        .reset_val_p (0)
    ) u_rpt_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (rpt_load),
        .value_i (rpt_val_lp),
        .done_o  (rpt_done)
    );
`endif

    // Next-state logic for the scan FSM, counter control and output values.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        pat_d    = pat_q;
        key_d    = key_q;
        cnt_load = 1'b0;
        cnt_val  = settle_val_lp;
`ifdef KPYD_SCAN_REPEAT_EN
        rpt_load = 1'b0;
`endif

        unique case (state_q)
            scan_s: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    if (row_i != '0) begin
                        pat_d   = row_i;
                        cnt_val = deb_val_lp;
                        state_d = debounce_s;
                    end else begin
                        col_d   = col_inc;
                        cnt_val = settle_val_lp;
                    end
                end
            end

            debounce_s: begin
                if (row_i != pat_q) begin
                    // Any change, including an added row, rejects the press.
                    col_d    = col_inc;
                    cnt_load = 1'b1;
                    cnt_val  = settle_val_lp;
                    state_d  = scan_s;
                end else if (cnt_done) begin
                    key_d   = key_w_lp'(kpyd_key_encode(KPYD_MAX_ROWS'(pat_q), rows_p,
                                                        cols_p, 32'(col_q)));
                    state_d = report_s;
                end
            end

            report_s: begin
                // Row changes are ignored here; the key is already accepted.
                if (ready_i) begin
                    cnt_load = 1'b1;
                    cnt_val  = deb_val_lp;
                    state_d  = release_s;
`ifdef KPYD_SCAN_REPEAT_EN
                    rpt_load = 1'b1;
`endif
                end
            end

            release_s: begin
`ifdef KPYD_SCAN_REPEAT_EN
                if (row_i != pat_q) begin
                    rpt_load = 1'b1;
                end
                if ((row_i == pat_q) && rpt_done) begin
                    state_d = report_s;
                end else
`endif
                if (row_i != '0) begin
                    cnt_load = 1'b1;
                    cnt_val  = deb_val_lp;
                end else if (cnt_done) begin
                    col_d    = col_inc;
                    cnt_load = 1'b1;
                    cnt_val  = settle_val_lp;
                    state_d  = scan_s;
                end
            end

            default: begin
                state_d = scan_s;
            end
        endcase

        valid_d  = (state_d == report_s);
        col_oh_d = '0;
        col_oh_d[col_d] = 1'b1;
    end

    // FSM state, scan position, captured pattern and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= scan_s;
            col_q    <= '0;
            pat_q    <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            col_oh_q <= cols_p'(1);
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            pat_q    <= pat_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            col_oh_q <= col_oh_d;
        end
    end

    assign col_o   = col_oh_q;
    assign key_o   = key_q;
    assign valid_o = valid_q;

endmodule

// File: doc/kpyd_scan_ctrl.md
# kpyd_scan_ctrl

Keypad scan controller for the kpyd subsystem. It walks a one-hot column drive across a `rows_p` x `cols_p` matrix keypad and samples the row lines. It debounces a detected press and emits exactly one key code per press on a valid/ready interface. It sits between the keypad pins (behind the row synchronizers) and the consumer of key events.

## Interface
- `cols_p`, default 4: number of keypad columns.
- `rows_p`, default 4: number of keypad rows.
- `settle_cycles_p`, default 16: cycles to wait after changing the column drive before row samples are trusted; must be ≥1.
- `debounce_cycles_p`, default 1000: consecutive stable samples required to accept a press or a release; must be ≥1.
- `repeat_cycles_p`, default 500000: hold time before auto-repeat; used only with `KPYD_SCAN_REPEAT_EN`.
- `key_w_lp` (localparam): `$clog2(rows_p*cols_p)`.

Ports:
- `clk_i` input 1: single clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `row_i` input `rows_p`: row lines, already synchronized to `clk_i`; 1 = pressed.
- `col_o` output `cols_p`: one-hot column drive.
- `key_o` output `key_w_lp`: key code = row*cols_p + col.
- `valid_o` output 1: `key_o` is valid.
- `ready_i` input 1: consumer accepts the key.

## Operation
The block is a four-state FSM with one shared down-counter. Column index `col_r` and captured pattern `pat_r` are registered.

- **`scan_s`**
  - Drive column `col_r`.
  - Wait `settle_cycles_p` cycles, then sample `row_i`.
  - If the sample is nonzero: capture it into `pat_r`, load the debounce count, go to `debounce_s`.
  - Otherwise: `col_r` increments, wrapping from `cols_p-1` to 0, and settle restarts.
- **`debounce_s`**
  - Each cycle, compare `row_i` against `pat_r`.
  - If they differ, the press is rejected: advance to the next column and return to `scan_s`.
  - After `debounce_cycles_p` consecutive matches, go to `report_s`.
- **`report_s`**
  - `valid_o` = 1; `key_o` = lowest set row index in `pat_r` × `cols_p` + `col_r`.
  - On `valid_o & ready_i`, go to `release_s`.
  - `key_o` is held stable while `valid_o` is high.
- **`release_s`**
  - The column drive stays on `col_r`.
  - The counter reloads whenever `row_i != 0`.
  - After `debounce_cycles_p` consecutive all-zero samples, advance the column and go to `scan_s`.

Boundary conditions:
- **Multiple rows in one column:** the lowest row index wins. Other columns are ignored until release.
- **Pattern change during debounce** (for example, a second row added): treated as a mismatch, so the press is rejected and scanning resumes.
- **Pattern change in `report_s`:** ignored; the key is already accepted.
- **Wrap:** the column after `cols_p-1` is 0.
- **Reset mid-operation:** asynchronous. The FSM returns immediately to `scan_s` with column 0, `valid_o` = 0, and the counter reloaded with `settle_cycles_p`.

## Timing
Reset values:
- `col_o` = one-hot bit 0
- `key_o` = 0
- `valid_o` = 0
- state = `scan_s`

Latency and handshake:
- Column dwell with no press: `settle_cycles_p` + 1 cycles per column.
- From the first sampled press cycle, `valid_o` rises `debounce_cycles_p` + 1 cycles later.
- `valid_o` drops the cycle after the handshake.
- `ready_i` may be high before `valid_o`; the handshake then completes in the first `valid_o` cycle.
- No combinational path from `ready_i` or `row_i` to any output. All outputs are registered.
- Counter width: `$clog2` of the maximum of all cycle parameters, plus 1.

## Configuration
- **`KPYD_SCAN_REPEAT_EN` defined:** in `release_s`, while the same `pat_r` is held continuously for `repeat_cycles_p` cycles, the FSM returns to `report_s` and re-reports the same `key_o`. The repeat counter restarts after each accepted repeat.
- **`KPYD_SCAN_REPEAT_EN` undefined:** exactly one report per press, and `repeat_cycles_p` is unused.

## Structure
- **Package `kpyd_pkg`:** holds the state enum `scan_state_e` (`scan_s`, `debounce_s`, `report_s`, `release_s`) and the function that encodes lowest-set-row plus column into a key code.
- **Sub-module `kpyd_delay_counter`:** loadable down-counter with `load_i`, `value_i` and `done_o`. It is shared across settle, debounce and release.

## Test plan
Parameters: `rows_p` = `cols_p` = 4, `settle_cycles_p` = 2, `debounce_cycles_p` = 4, `repeat_cycles_p` = 20.

- **Idle scan:** `row_i` = 0 for 40 cycles → `col_o` cycles 0001→0010→0100→1000→0001 every 3 cycles; `valid_o` stays 0.
- **Clean press, key row 2 / col 1:** `ready_i` = 1 → `key_o` = 9 with a single-cycle `valid_o`. No second report until the row has been 0 for 4 cycles and then is pressed again.
- **Bounce:** row pattern toggles 1-0-1 within 4 cycles during debounce → no `valid_o`; scanning resumes at the next column.
- **Backpressure and multi-row:** `ready_i` = 0 for 10 cycles while rows 1 and 3 are pressed in column 3 → `valid_o` held with `key_o` = 7 constant; accepted on the first `ready_i` = 1.
- **Async reset:** assert `reset_i` mid-`report_s` → `valid_o` = 0 and `col_o` = 0001 without waiting for a clock edge.
- **`KPYD_SCAN_REPEAT_EN`:** hold key 0 for 60 cycles → repeated reports of `key_o` = 0 spaced 20 cycles apart. With the macro undefined, the same stimulus gives exactly one report.
